// File: rtl/counter_pkg.sv
// Shared types for the sequenced counter.
// State encodings and the default counter width.
package counter_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/counter8_en_async_resetb.sv
// Counter datapath: synchronous clear over enable.
// Wraps modulo 2^WIDTH.
module counter8_en_async_resetb
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] result
);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)
         result <= '0;
      else if (clr)
         result <= '0;
      else if (en)
         result <= result + 1'b1;
   end

endmodule

// File: rtl/counter8_seq_ctrl.sv
// Sequenced up-counter with one-shot/periodic modes,
// pause, abort and a registered terminal-count pulse.
module counter8_seq_ctrl
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             start,
   input  logic             abort,
   input  logic             pause,
   input  logic             periodic,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             start_err,
   output logic [1:0]       state
);

   state_t           cur, nxt;
   logic [WIDTH-1:0] per_q;
   logic             mode_q;
   logic             en, clr, ld;
   logic             done_n, err_n;

   assign busy  = (cur == ST_RUN) || (cur == ST_PAUSE);
   assign state = cur;

   counter8_en_async_resetb #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .resetb (resetb),
      .en     (en),
      .clr    (clr),
      .result (count)
   );

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cur       <= ST_IDLE;
         per_q     <= '0;
         mode_q    <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
      end else begin
         cur       <= nxt;
         done      <= done_n;
         start_err <= err_n;
         if (ld) begin
            per_q  <= period;
            mode_q <= periodic;
         end
      end
   end

   // Priority: abort, start, pause/resume, counting.
   always_comb begin
      nxt    = cur;
      en     = 1'b0;
      clr    = 1'b0;
      ld     = 1'b0;
      done_n = 1'b0;
      err_n  = 1'b0;
      if (abort) begin
         nxt = ST_IDLE;
         clr = 1'b1;
      end else if (start && !busy) begin
         nxt = ST_RUN;
         clr = 1'b1;
         ld  = 1'b1;
      end else if (start) begin
         err_n = 1'b1;
      end else begin
         unique case (cur)
            ST_RUN: begin
               if (pause) begin
                  nxt = ST_PAUSE;
               end else if (count == per_q) begin
                  done_n = 1'b1;
                  if (mode_q)
                     clr = 1'b1;
                  else
                     nxt = ST_DONE;
               end else begin
                  en = 1'b1;
               end
            end
            ST_PAUSE: begin
               if (!pause)
                  nxt = ST_RUN;
            end
            ST_IDLE, ST_DONE: ;
         endcase
      end
   end

endmodule
